lb_config_ctrl: RTL and testbench

- Configuration sequencer for an array of logic blocks.
- Accepts single-write and burst configuration commands from the host/config bus over a valid/ready handshake.
- Drives a one-hot per-block config_en vector and a broadcast config_data bus into the logic blocks' config registers.
- Reports completion, errors and a write count.

---
 rtl/lb_config_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_lb_config_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lb_config_ctrl.sv
// lb_config_ctrl: configuration sequencer for an array of logic blocks.
// Accepts single writes and bursts over a valid/ready handshake. It drives a
// one-hot config_en strobe and a broadcast config_data word, and reports done,
// err and a saturating write count.
// Optional readback shadow registers are enabled by defining
// LB_CONFIG_READBACK_EN.
//
// Handshake: a beat is accepted on a rising clk edge where
// cmd_valid & cmd_ready are both high. cmd_ready does not depend on cmd_valid.
// A beat stays pending while cmd_valid is high and cmd_ready is low.
module lb_config_ctrl #(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = 3,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_burst,
  input  logic [IDX_W-1:0]      cmd_idx,
  input  logic [DATA_W-1:0]     cmd_data,
  output logic [NUM_BLOCKS-1:0] config_en,
  output logic [DATA_W-1:0]     config_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      wr_count,
`ifdef LB_CONFIG_READBACK_EN
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_W-1:0]     rd_data,
`endif
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [31:0]      NB_U     = NUM_BLOCKS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W:0]          rem_q, rem_d;
  logic [NUM_BLOCKS-1:0]   en_q, en_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    ready_q, ready_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    accept;
  logic [IDX_W:0]          hdr_len;
  logic                    idx_ok;
  logic                    len_ok;
  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;

  assign accept  = cmd_valid & ready_q;
  assign hdr_len = cmd_data[IDX_W:0];
  assign idx_ok  = (32'(cmd_idx) < NB_U);
  assign len_ok  = (32'(hdr_len) <= NB_U);

  // State and datapath registers; reset drops any in-flight strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      en_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      en_q    <= en_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: header beats start a burst, and the last burst beat
  // enters DONE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (accept && cmd_burst && idx_ok && len_ok && (hdr_len != '0)) begin
          state_d = S_BURST;
          ptr_d   = cmd_idx;
          rem_d   = hdr_len;
        end
      end
      S_BURST: begin
        if (accept) begin
          ptr_d = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == {{IDX_W{1'b0}}, 1'b1}) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: compute the registered strobe, data, status pulses and count
  // for the next cycle.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = cmd_idx;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!cmd_burst) begin
            wr_en  = idx_ok;
            done_d = idx_ok;
            err_d  = !idx_ok;
          end else begin
            err_d  = !(idx_ok && len_ok);
            done_d = idx_ok && len_ok && (hdr_len == '0);
          end
        end
      end
      S_BURST: begin
        if (accept) begin
          wr_en  = 1'b1;
          wr_idx = ptr_q;
          done_d = (rem_q == {{IDX_W{1'b0}}, 1'b1});
        end
      end
      default: ;
    endcase
    en_d    = wr_en ? ({{(NUM_BLOCKS-1){1'b0}}, 1'b1} << wr_idx) : '0;
    data_d  = wr_en ? cmd_data : data_q;
    cnt_d   = (wr_en && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    ready_d = (state_d != S_DONE);
  end

  assign cmd_ready   = ready_q;
  assign config_en   = en_q;
  assign config_data = data_q;
  assign done        = done_q;
  assign err         = err_q;
  assign wr_count    = cnt_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

`ifdef LB_CONFIG_READBACK_EN
  logic [DATA_W-1:0] shadow_q [NUM_BLOCKS];
  logic [DATA_W-1:0] shadow_d [NUM_BLOCKS];
  logic [DATA_W-1:0] rd_q, rd_d;

  // Shadows update on the same edge that launches config_en.
  // A read in the same cycle returns the old word.
  always_comb begin
    for (int i = 0; i < NUM_BLOCKS; i++) shadow_d[i] = shadow_q[i];
    if (wr_en) shadow_d[wr_idx] = cmd_data;
    rd_d = (32'(rd_idx) < NB_U) ? shadow_q[rd_idx] : '0;
  end

  // Shadow and readback registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_BLOCKS; i++) shadow_q[i] <= '0;
      rd_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BLOCKS; i++) shadow_q[i] <= shadow_d[i];
      rd_q <= rd_d;
    end
  end

  assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_lb_config_ctrl.sv
// tb_lb_config_ctrl: a table of directed vectors, hand-written multi-cycle
// sequences and randomized traffic checked against a behavioural model.
// Define LB_CONFIG_READBACK_EN to exercise the readback ports.
module tb_lb_config_ctrl;
  localparam int NB = 8;
  localparam int IW = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_burst;
  logic [IW-1:0] cmd_idx;
  logic [DW-1:0] cmd_data;
  logic [NB-1:0] config_en;
  logic [DW-1:0] config_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] wr_count;
  logic [1:0]    dbg_state;
`ifdef LB_CONFIG_READBACK_EN
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] rd_data;
`endif

  int checks;
  int failures;
  logic [NB+DW-1:0] exp_q[$];

  lb_config_ctrl #(.NUM_BLOCKS(NB), .IDX_W(IW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_burst(cmd_burst), .cmd_idx(cmd_idx), .cmd_data(cmd_data),
    .config_en(config_en), .config_data(config_data), .busy(busy),
    .done(done), .err(err), .wr_count(wr_count),
`ifdef LB_CONFIG_READBACK_EN
    .rd_idx(rd_idx), .rd_data(rd_data),
`endif
    .dbg_state(dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic          b;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic [NB-1:0] en;
    logic [DW-1:0] cd;
    logic          dn;
    logic          er;
    logic          bz;
    logic          rdy;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_row(input int i, input int v, input int b, input int idx, input int data,
                         input int en, input int cd, input int dn, input int er, input int bz,
                         input int rdy, input int cnt);
    tbl[i].v = 1'(v);     tbl[i].b = 1'(b);     tbl[i].idx = IW'(idx);
    tbl[i].data = DW'(data); tbl[i].en = NB'(en); tbl[i].cd = DW'(cd);
    tbl[i].dn = 1'(dn);   tbl[i].er = 1'(er);   tbl[i].bz = 1'(bz);
    tbl[i].rdy = 1'(rdy); tbl[i].cnt = CW'(cnt);
  endtask

  // Driver: present one beat, then advance to just after the next rising edge.
  task automatic drive(input logic v, input logic b, input logic [IW-1:0] idx,
                       input logic [DW-1:0] data);
    cmd_valid = v; cmd_burst = b; cmd_idx = idx; cmd_data = data;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [NB-1:0] en, input logic dn,
                         input logic er, input logic bz, input logic rdy, input logic [CW-1:0] cnt);
    chk({tag, ".config_en"}, 64'(config_en), 64'(en));
    chk({tag, ".done"}, 64'(done), 64'(dn));
    chk({tag, ".err"}, 64'(err), 64'(er));
    chk({tag, ".busy"}, 64'(busy), 64'(bz));
    chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'(rdy));
    chk({tag, ".wr_count"}, 64'(wr_count), 64'(cnt));
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0; cmd_burst = 1'b0; cmd_idx = '0; cmd_data = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("reset.config_data", 64'(config_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("release.cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  // Behavioural model state for the randomized phase.
  bit            m_burst;
  bit            m_done_cyc;
  int            m_ptr;
  int            m_rem;
  int            m_cnt;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_shadow [NB];

  initial begin
    checks = 0;
    failures = 0;
    cmd_valid = 1'b0; cmd_burst = 1'b0; cmd_idx = '0; cmd_data = '0;
`ifdef LB_CONFIG_READBACK_EN
    rd_idx = '0;
`endif
    rst = 1'b0;

    //       i  v  b idx data   en    cd dn er bz rdy cnt
    set_row(0,  1, 0, 2, 1,     'h04, 1, 1, 0, 0, 1, 1);
    set_row(1,  1, 1, 6, 4,     'h00, 1, 0, 0, 1, 1, 1);
    set_row(2,  1, 0, 0, 0,     'h40, 0, 0, 0, 1, 1, 2);
    set_row(3,  1, 1, 0, 1,     'h80, 1, 0, 0, 1, 1, 3);
    set_row(4,  1, 0, 0, 2,     'h01, 2, 0, 0, 1, 1, 4);
    set_row(5,  1, 0, 0, 3,     'h02, 3, 1, 0, 1, 0, 5);
    set_row(6,  1, 0, 2, 99,    'h00, 3, 0, 0, 0, 1, 5);
    set_row(7,  1, 0, 8, 7,     'h00, 3, 0, 1, 0, 1, 5);
    set_row(8,  1, 1, 0, 9,     'h00, 3, 0, 1, 0, 1, 5);
    set_row(9,  1, 1, 0, 0,     'h00, 3, 1, 0, 0, 1, 5);
    set_row(10, 1, 1, 9, 2,     'h00, 3, 0, 1, 0, 1, 5);
    set_row(11, 0, 0, 0, 0,     'h00, 3, 0, 0, 0, 1, 5);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].b, tbl[i].idx, tbl[i].data);
      chk_out($sformatf("row%0d", i), tbl[i].en, tbl[i].dn, tbl[i].er, tbl[i].bz,
              tbl[i].rdy, tbl[i].cnt);
      chk($sformatf("row%0d.config_data", i), 64'(config_data), 64'(tbl[i].cd));
    end

    // Burst of 3 with stalls between beats and a reset after the second beat.
    drive(1'b1, 1'b1, 4'd5, 32'd3);
    chk_out("stall.hdr", '0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
    drive(1'b1, 1'b0, 4'd0, 32'hAA);
    chk_out("stall.b0", 8'h20, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6);
    drive(1'b0, 1'b0, 4'd0, 32'h11);
    chk_out("stall.gap0", '0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6);
    drive(1'b0, 1'b0, 4'd0, 32'h22);
    chk_out("stall.gap1", '0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6);
    chk("stall.gap.config_data", 64'(config_data), 64'hAA);
    drive(1'b1, 1'b0, 4'd0, 32'hBB);
    chk_out("stall.b1", 8'h40, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7);
    cmd_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_out("midrst", '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.release.cmd_ready", 64'(cmd_ready), 64'd1);
    drive(1'b1, 1'b0, 4'd1, 32'h55);
    chk_out("postrst.single", 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    chk("postrst.config_data", 64'(config_data), 64'h55);

`ifdef LB_CONFIG_READBACK_EN
    do_reset();
    drive(1'b1, 1'b0, 4'd3, 32'hA5);
    rd_idx = 4'd3;
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    chk("rb.idx3", 64'(rd_data), 64'hA5);
    rd_idx = 4'd5;
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    chk("rb.idx5", 64'(rd_data), 64'h0);
    rd_idx = 4'd9;
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    chk("rb.idx9", 64'(rd_data), 64'h0);
    rd_idx = 4'd3;
    drive(1'b1, 1'b0, 4'd3, 32'h77);
    chk("rb.same_cycle_old", 64'(rd_data), 64'hA5);
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    chk("rb.same_cycle_new", 64'(rd_data), 64'h77);
`endif

    // Randomized traffic against the behavioural model.
    do_reset();
    m_burst = 0; m_done_cyc = 0; m_ptr = 0; m_rem = 0; m_cnt = 0; m_data = '0;
    for (int i = 0; i < NB; i++) m_shadow[i] = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic          v, b, wrote, e_done, e_err;
      logic [IW-1:0] idx;
      logic [DW-1:0] data;
      logic [NB-1:0] e_en;
      int            widx, len;
`ifdef LB_CONFIG_READBACK_EN
      logic [DW-1:0] e_rd;
      rd_idx = IW'($urandom_range(0, 11));
      e_rd = (int'(rd_idx) < NB) ? m_shadow[rd_idx] : '0;
`endif
      v = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 3) == 0);
      idx = ($urandom_range(0, 5) == 0) ? IW'($urandom_range(8, 15)) : IW'($urandom_range(0, 7));
      data = $urandom;
      if (b) data[IW:0] = 5'($urandom_range(0, 10));
      len = int'(data[IW:0]);
      wrote = 0; widx = 0; e_done = 0; e_err = 0;

      if (m_done_cyc) begin
        m_done_cyc = 0;
      end else if (m_burst) begin
        if (v) begin
          wrote = 1; widx = m_ptr;
          m_ptr = (m_ptr + 1) % NB;
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_burst = 0; m_done_cyc = 1; e_done = 1;
          end
        end
      end else if (v) begin
        if (!b) begin
          if (int'(idx) < NB) begin
            wrote = 1; widx = int'(idx); e_done = 1;
          end else e_err = 1;
        end else if (int'(idx) >= NB || len > NB) begin
          e_err = 1;
        end else if (len == 0) begin
          e_done = 1;
        end else begin
          m_burst = 1; m_ptr = int'(idx); m_rem = len;
        end
      end

      e_en = '0;
      if (wrote) begin
        e_en = NB'(1) << widx;
        m_data = data;
        m_shadow[widx] = data;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        exp_q.push_back({e_en, data});
      end

      drive(v, b, idx, data);
      chk_out("rand", e_en, e_done, e_err, 1'(m_burst || m_done_cyc), 1'(!m_done_cyc), CW'(m_cnt));
      chk("rand.config_data", 64'(config_data), 64'(m_data));
`ifdef LB_CONFIG_READBACK_EN
      chk("rand.rd_data", 64'(rd_data), 64'(e_rd));
`endif
      if (config_en != '0) begin
        if (exp_q.size() == 0) begin
          chk("sb.unexpected_write", 64'(config_en), 64'd0);
        end else begin
          logic [NB+DW-1:0] exp_w;
          exp_w = exp_q.pop_front();
          chk("sb.write", 64'({config_en, config_data}), 64'(exp_w));
        end
      end
    end
    chk("sb.leftover", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
